// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receive FIFO and its consumer. It carries the serial line in,
// the show-ahead read port and the sticky status flags.
interface uart_rx_fifo_if #(
    parameter int FifoDepthLog2 = 2
);
    logic                   RxD;
    logic                   rd_en;
    logic                   err_clr;
    logic [7:0]             rd_data;
    logic                   rd_valid;
    logic [FifoDepthLog2:0] fifo_count;
    logic                   rx_busy;
    logic                   frame_err;
    logic                   overflow;

    modport slave (
        input  RxD, rd_en, err_clr,
        output rd_data, rd_valid, fifo_count, rx_busy, frame_err, overflow
    );

    modport master (
        output RxD, rd_en, err_clr,
        input  rd_data, rd_valid, fifo_count, rx_busy, frame_err, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with start-glitch rejection, 3-sample majority voting, and a small
// show-ahead receive FIFO that has sticky framing-error and overflow flags.
module uart_rx_fifo #(
    parameter int ClkFrequency  = 10000000,
    parameter int Baud          = 230400,
    parameter int FifoDepthLog2 = 2
) (
    input  logic           CLK_10MHZ,
    input  logic           rst_n,
    uart_rx_fifo_if.slave  bus
);
    localparam int BIT_CLKS = ClkFrequency / Baud;
    localparam int HALF     = BIT_CLKS / 2;
    localparam int CNT_W    = $clog2(BIT_CLKS);
    localparam int DEPTH    = 2 ** FifoDepthLog2;
    localparam int CW       = FifoDepthLog2 + 1;

    localparam logic [CNT_W-1:0]         TMR_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]         TMR_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]         TMR_LAST = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0]         TMR_S0   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]         TMR_S1   = CNT_W'(HALF);
    localparam logic [CNT_W-1:0]         TMR_DEC  = CNT_W'(HALF + 1);
    localparam logic [CW-1:0]            CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]            CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]            FULL_CNT = CW'(DEPTH);
    localparam logic [FifoDepthLog2-1:0] PTR_ONE  = FifoDepthLog2'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BRK   = 3'd4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic                     sync1_q, rxs_q;
    logic [2:0]               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_next_s;
    logic [2:0]               bit_idx_q, bit_idx_d;
    logic [1:0]               samp_q, samp_d;
    logic [7:0]               shreg_q, shreg_d;
    logic                     push_q, push_d;
    logic [7:0]               push_data_q, push_data_d;
    logic                     bit_val_s, decide_s, bit_end_s, ferr_set_s;
    logic [7:0]               mem_q [DEPTH];
    logic [FifoDepthLog2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [7:0]               rd_data_q, rd_data_d;
    logic                     rd_valid_q, rd_valid_d;
    logic                     rx_busy_q;
    logic                     frame_err_q, frame_err_d, overflow_q, overflow_d;
    logic                     pop_s, full_s, wr_s, drop_s;

    // Both flops idle high so that reset release never looks like a start bit.
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= bus.RxD;
            rxs_q   <= sync1_q;
        end
    end

    // Receiver FSM: bit timer, mid-bit sampling, shift register and stop-bit decision.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        ferr_set_s  = 1'b0;
        bit_val_s   = maj3(samp_q[0], samp_q[1], rxs_q);
        decide_s    = (cnt_q == TMR_DEC);
        bit_end_s   = (cnt_q == TMR_LAST);
        cnt_next_s  = bit_end_s ? TMR_ZERO : (cnt_q + TMR_ONE);
        cnt_d       = cnt_next_s;
        if (cnt_q == TMR_S0) begin
            samp_d = {samp_q[1], rxs_q};
        end else if (cnt_q == TMR_S1) begin
            samp_d = {rxs_q, samp_q[0]};
        end else begin
            samp_d = samp_q;
        end
        case (state_q)
            ST_IDLE: begin
                cnt_d = TMR_ZERO;
                if (!rxs_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (decide_s && bit_val_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = TMR_ZERO;
                end else if (bit_end_s) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (decide_s) begin
                    shreg_d = {bit_val_s, shreg_q[7:1]};
                end else begin
                    shreg_d = shreg_q;
                end
                if (bit_end_s && (bit_idx_q == 3'd7)) begin
                    state_d = ST_STOP;
                end else if (bit_end_s) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    bit_idx_d = bit_idx_q;
                end
            end
            ST_STOP: begin
                // Leaving mid stop bit lets the next start edge of a back-to-back frame be seen.
                if (decide_s && bit_val_s) begin
                    push_d      = 1'b1;
                    push_data_d = shreg_q;
                    state_d     = ST_IDLE;
                    cnt_d       = TMR_ZERO;
                end else if (decide_s) begin
                    ferr_set_s = 1'b1;
                    state_d    = ST_BRK;
                    cnt_d      = TMR_ZERO;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_BRK: begin
                cnt_d = TMR_ZERO;
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BRK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = TMR_ZERO;
            end
        endcase
    end

    // FIFO next state. rd_data/rd_valid are computed from the post-edge pointers so the
    // registered head always matches fifo_count.
    always_comb begin
        pop_s  = bus.rd_en & rd_valid_q;
        full_s = (count_q == FULL_CNT);
        wr_s   = push_q & (~full_s | pop_s);
        drop_s = push_q & full_s & ~pop_s;
        if (pop_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
        if (wr_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        case ({wr_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (wr_s && (wptr_q == rptr_d)) begin
            rd_data_d = push_data_q;
        end else begin
            rd_data_d = mem_q[rptr_d];
        end
        rd_valid_d  = (count_d != CNT_ZERO);
        frame_err_d = ferr_set_s ? 1'b1 : (bus.err_clr ? 1'b0 : frame_err_q);
        overflow_d  = drop_s     ? 1'b1 : (bus.err_clr ? 1'b0 : overflow_q);
    end

    // State, FIFO storage and registered outputs.
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= TMR_ZERO;
            bit_idx_q   <= 3'd0;
            samp_q      <= 2'b11;
            shreg_q     <= 8'h00;
            push_q      <= 1'b0;
            push_data_q <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= CNT_ZERO;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            samp_q      <= samp_d;
            shreg_q     <= shreg_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            if (wr_s) begin
                mem_q[wptr_q] <= push_data_q;
            end
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rx_busy_q   <= (state_d != ST_IDLE);
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.fifo_count = count_q;
    assign bus.rx_busy    = rx_busy_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue-based reference FIFO is checked every cycle,
// and hand-computed literal expectations back it up.
module tb_uart_rx_fifo;
    localparam int DEPTH = 4;
    localparam int PUSH_LAT = 414;  // drive-start edge to FIFO write edge: 2 sync + start detect + 9.5 bits of 43 + push register
    localparam int FERR_LAT = 413;  // stop-bit decision edge

    typedef struct {
        int         t;
        int         kind;   // 0 = byte arrives, 1 = framing error
        logic [7:0] d;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   cmp_en = 1'b0;

    logic [7:0] m_q [$];
    logic       m_ferr = 1'b0;
    logic       m_ovf = 1'b0;
    ev_t        sched [$];
    ev_t        keep [$];
    logic       m_push, m_fset, m_pop;
    logic [7:0] m_pdata;
    int         m_pre;

    uart_rx_fifo_if #(.FifoDepthLog2(2)) bus ();

    uart_rx_fifo #(
        .ClkFrequency (10000000),
        .Baud         (230400),
        .FifoDepthLog2(2)
    ) dut (
        .CLK_10MHZ(clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: applies byte arrivals, errors, pops and clears at each clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            sched.delete();
            m_ferr = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            cyc++;
            m_push = 1'b0;
            m_fset = 1'b0;
            m_pdata = 8'h00;
            keep.delete();
            foreach (sched[i]) begin
                if (sched[i].t == cyc) begin
                    if (sched[i].kind == 0) begin
                        m_push  = 1'b1;
                        m_pdata = sched[i].d;
                    end else begin
                        m_fset = 1'b1;
                    end
                end else begin
                    keep.push_back(sched[i]);
                end
            end
            sched = keep;
            m_pre = m_q.size();
            m_pop = bus.rd_en && (m_pre != 0);
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_pre == DEPTH && !m_pop) m_ovf = 1'b1;
                else m_q.push_back(m_pdata);
            end else if (bus.err_clr) begin
                m_ovf = 1'b0;
            end
            if (m_fset) m_ferr = 1'b1;
            else if (bus.err_clr) m_ferr = 1'b0;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_count", int'(bus.fifo_count), m_q.size());
            chk("model_valid", int'(bus.rd_valid), int'(m_q.size() != 0));
            if (m_q.size() != 0) chk("model_data", int'(bus.rd_data), int'(m_q[0]));
            chk("model_frame_err", int'(bus.frame_err), int'(m_ferr));
            chk("model_overflow", int'(bus.overflow), int'(m_ovf));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the first nbits bits of a frame (start, 8 data LSB first, stop), period clocks each.
    task automatic send_frame(input logic [7:0] data, input int period, input logic stop_bit,
                              input int nbits, input bit pop_at_push);
        logic [9:0] fr;
        ev_t        e;
        fr = {stop_bit, data, 1'b0};
        if (nbits == 10) begin
            e.t    = cyc + (stop_bit ? PUSH_LAT : FERR_LAT);
            e.kind = stop_bit ? 0 : 1;
            e.d    = data;
            sched.push_back(e);
        end
        for (int i = 0; i < nbits * period; i++) begin
            bus.RxD   = fr[i / period];
            bus.rd_en = pop_at_push && (i == PUSH_LAT - 1);
            tick(1);
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic pop_expect(input string nm, input logic [7:0] exp);
        chk({nm, "_valid"}, int'(bus.rd_valid), 1);
        chk({nm, "_data"}, int'(bus.rd_data), int'(exp));
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [7:0] t5_bytes [3];
        t5_bytes[0] = 8'h00;
        t5_bytes[1] = 8'hFF;
        t5_bytes[2] = 8'h96;
        bus.RxD = 1'b1;
        bus.rd_en = 1'b0;
        bus.err_clr = 1'b0;
        tick(3);
        cmp_en = 1'b1;
        chk("reset_data", int'(bus.rd_data), 0);
        chk("reset_valid", int'(bus.rd_valid), 0);
        chk("reset_count", int'(bus.fifo_count), 0);
        chk("reset_busy", int'(bus.rx_busy), 0);
        chk("reset_flags", int'({bus.frame_err, bus.overflow}), 0);
        rst_n = 1'b1;
        tick(20);

        // 1: single byte, then pop
        send_frame(8'h55, 43, 1'b1, 10, 1'b0);
        tick(5);
        chk("t1_valid", int'(bus.rd_valid), 1);
        chk("t1_data", int'(bus.rd_data), 8'h55);
        chk("t1_count", int'(bus.fifo_count), 1);
        chk("t1_ferr", int'(bus.frame_err), 0);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        tick(1);
        chk("t1_valid_after_pop", int'(bus.rd_valid), 0);
        chk("t1_count_after_pop", int'(bus.fifo_count), 0);
        bus.rd_en = 1'b1;           // pop on empty must do nothing
        tick(2);
        bus.rd_en = 1'b0;
        chk("t1_empty_pop_count", int'(bus.fifo_count), 0);

        // 2: start glitch
        tick(20);
        bus.RxD = 1'b0;
        tick(10);
        chk("t2_busy_during", int'(bus.rx_busy), 1);
        bus.RxD = 1'b1;
        tick(60);
        chk("t2_busy_after", int'(bus.rx_busy), 0);
        chk("t2_count", int'(bus.fifo_count), 0);
        chk("t2_ferr", int'(bus.frame_err), 0);

        // 3: framing error, held-low break, then a good byte
        send_frame(8'hA5, 43, 1'b0, 10, 1'b0);
        tick(300);
        chk("t3_ferr_set", int'(bus.frame_err), 1);
        chk("t3_busy_in_break", int'(bus.rx_busy), 1);
        bus.RxD = 1'b1;
        tick(50);
        send_frame(8'h3C, 43, 1'b1, 10, 1'b0);
        tick(5);
        chk("t3_count", int'(bus.fifo_count), 1);
        chk("t3_data", int'(bus.rd_data), 8'h3C);
        chk("t3_ferr_held", int'(bus.frame_err), 1);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        tick(1);
        chk("t3_ferr_clr", int'(bus.frame_err), 0);
        pop_expect("t3_pop", 8'h3C);

        // 4: overflow with five back-to-back bytes
        tick(20);
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 43, 1'b1, 10, 1'b0);
        tick(5);
        chk("t4_count", int'(bus.fifo_count), 4);
        chk("t4_overflow", int'(bus.overflow), 1);
        for (int i = 1; i <= 4; i++) pop_expect("t4_pop", 8'(i));
        chk("t4_empty", int'(bus.rd_valid), 0);

        // 5: baud tolerance at 42 and 44 clocks per bit
        tick(20);
        for (int p = 42; p <= 44; p += 2) begin
            for (int i = 0; i < 3; i++) send_frame(t5_bytes[i], p, 1'b1, 10, 1'b0);
            tick(5);
            chk("t5_count", int'(bus.fifo_count), 3);
            for (int i = 0; i < 3; i++) pop_expect("t5_pop", t5_bytes[i]);
            tick(10);
        end
        chk("t5_ferr", int'(bus.frame_err), 0);

        // 6: reset mid-frame, then full FIFO with simultaneous push and pop
        send_frame(8'hC3, 43, 1'b1, 5, 1'b0);
        bus.RxD = 1'b0;
        tick(20);
        rst_n = 1'b0;
        tick(3);
        bus.RxD = 1'b1;
        chk("t6_reset_count", int'(bus.fifo_count), 0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        send_frame(8'h7E, 43, 1'b1, 10, 1'b0);
        tick(5);
        chk("t6_flags", int'({bus.frame_err, bus.overflow}), 0);
        chk("t6_count", int'(bus.fifo_count), 1);
        pop_expect("t6_pop", 8'h7E);
        tick(20);
        for (int i = 1; i <= 4; i++) send_frame(8'(8'h11 * i), 43, 1'b1, 10, 1'b0);
        send_frame(8'h55, 43, 1'b1, 10, 1'b1);
        tick(5);
        chk("t6_full_count", int'(bus.fifo_count), 4);
        chk("t6_no_overflow", int'(bus.overflow), 0);
        pop_expect("t6_pp0", 8'h22);
        pop_expect("t6_pp1", 8'h33);
        pop_expect("t6_pp2", 8'h44);
        pop_expect("t6_pp3", 8'h55);
        chk("t6_empty", int'(bus.rd_valid), 0);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
